// File: rtl/regfile_2r1w.sv
// 32-entry, 2-read/1-write register file with a post-reset clear sequence; r0 reads as zero.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to matching reads.
module regfile_2r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  readEnable1_i,
    input  logic [ADDR_WIDTH-1:0] readAddr1_i,
    output logic [DATA_WIDTH-1:0] readData1_o,
    input  logic                  readEnable2_i,
    input  logic [ADDR_WIDTH-1:0] readAddr2_i,
    output logic [DATA_WIDTH-1:0] readData2_o,
    input  logic                  writeEnable_i,
    input  logic [ADDR_WIDTH-1:0] writeAddr_i,
    input  logic [DATA_WIDTH-1:0] writeData_i,
    output logic                  ready_o,
    output logic                  writeDropped_o
);
    localparam int NUM_REGS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_REG = ADDR_WIDTH'(NUM_REGS - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clrPtr_q, clrPtr_d;
    logic                    ready_q, ready_d;
    logic                    dropped_q, dropped_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];

    logic                    rfWe;
    logic [ADDR_WIDTH-1:0]   rfAddr;
    logic [DATA_WIDTH-1:0]   rfData;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= CLEAR;
            clrPtr_q  <= ADDR_WIDTH'(1);
            ready_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clrPtr_q  <= clrPtr_d;
            ready_q   <= ready_d;
            dropped_q <= dropped_d;
        end
    end

    // Storage has no reset; the clear sequence shares the single write port.
    always_ff @(posedge clk) begin
        if (rst && rfWe)
            regs_q[rfAddr] <= rfData;
    end

    always_comb begin
        state_d   = state_q;
        clrPtr_d  = clrPtr_q;
        ready_d   = ready_q;
        dropped_d = 1'b0;
        rfWe      = 1'b0;
        rfAddr    = writeAddr_i;
        rfData    = writeData_i;
        case (state_q)
            CLEAR: begin
                rfWe      = 1'b1;
                rfAddr    = clrPtr_q;
                rfData    = '0;
                dropped_d = writeEnable_i;
                if (clrPtr_q == LAST_REG) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end else begin
                    clrPtr_d = clrPtr_q + 1'b1;
                end
            end
            RUN: begin
                rfWe    = writeEnable_i && (writeAddr_i != '0);
                ready_d = 1'b1;
            end
            default: state_d = CLEAR;
        endcase
    end

    function automatic logic [DATA_WIDTH-1:0] readPort(input logic en, input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] d;
        d = '0;
        if (rst && state_q == RUN && en && addr != '0) begin
            d = regs_q[addr];
`ifdef REGFILE_BYPASS_EN
            if (writeEnable_i && writeAddr_i == addr)
                d = writeData_i;
`endif
        end
        return d;
    endfunction

    always_comb begin
        readData1_o = readPort(readEnable1_i, readAddr1_i);
        readData2_o = readPort(readEnable2_i, readAddr2_i);
    end

    assign ready_o        = ready_q;
    assign writeDropped_o = dropped_q;
endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: clear sequence, writes, r0, bypass, drops, mid-run reset.
module tb_regfile_2r1w;
    logic        clk;
    logic        rst;
    logic        readEnable1_i, readEnable2_i, writeEnable_i;
    logic [4:0]  readAddr1_i, readAddr2_i, writeAddr_i;
    logic [31:0] readData1_o, readData2_o, writeData_i;
    logic        ready_o, writeDropped_o;

    int checks = 0;
    int errors = 0;

    regfile_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .readEnable1_i(readEnable1_i), .readAddr1_i(readAddr1_i), .readData1_o(readData1_o),
        .readEnable2_i(readEnable2_i), .readAddr2_i(readAddr2_i), .readData2_o(readData2_o),
        .writeEnable_i(writeEnable_i), .writeAddr_i(writeAddr_i), .writeData_i(writeData_i),
        .ready_o(ready_o), .writeDropped_o(writeDropped_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        writeEnable_i = 1'b1; writeAddr_i = a; writeData_i = d;
        tick();
        writeEnable_i = 1'b0;
    endtask

    // 31 edges with rst=1; drops injected on chosen edges and expected the cycle after.
    task automatic do_clear(input int pass);
        logic weNow;
        readEnable1_i = 1'b1; readAddr1_i = 5'd3;
        for (int e = 1; e <= 31; e++) begin
            weNow = (pass == 0 && e == 10) || (pass == 1 && (e == 2 || e == 3));
            writeEnable_i = weNow; writeAddr_i = 5'd3; writeData_i = 32'hABCD0000;
            #1;
            chk("clear_read_masked", readData1_o, 32'h0);
            tick();
            writeEnable_i = 1'b0;
            chk("clear_ready", 32'(ready_o), (e == 31) ? 32'd1 : 32'd0);
            chk("clear_dropped", 32'(writeDropped_o), 32'(weNow));
        end
    endtask

    task automatic check_all_zero();
        readEnable1_i = 1'b1; readEnable2_i = 1'b1;
        for (int r = 1; r < 32; r++) begin
            readAddr1_i = 5'(r); readAddr2_i = 5'(r);
            #1;
            chk("zero_p1", readData1_o, 32'h0);
            chk("zero_p2", readData2_o, 32'h0);
        end
    endtask

    initial begin
        rst = 1'b0;
        readEnable1_i = 1'b1; readAddr1_i = 5'd5;
        readEnable2_i = 1'b1; readAddr2_i = 5'd5;
        writeEnable_i = 1'b0; writeAddr_i = '0; writeData_i = '0;
        tick();
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_dropped", 32'(writeDropped_o), 32'd0);
        chk("rst_rd1", readData1_o, 32'h0);
        chk("rst_rd2", readData2_o, 32'h0);

        rst = 1'b1;
        do_clear(0);
        check_all_zero();

        // write then read on both ports
        wr(5'd5, 32'hDEADBEEF);
        readAddr1_i = 5'd5; readAddr2_i = 5'd5; #1;
        chk("r5_p1", readData1_o, 32'hDEADBEEF);
        chk("r5_p2", readData2_o, 32'hDEADBEEF);

        // r0 write is ignored and not a drop
        wr(5'd0, 32'hFFFFFFFF);
        chk("r0_no_drop", 32'(writeDropped_o), 32'd0);
        readAddr1_i = 5'd0; #1;
        chk("r0_read", readData1_o, 32'h0);

        // same-cycle read/write
        wr(5'd7, 32'h11111111);
        writeEnable_i = 1'b1; writeAddr_i = 5'd7; writeData_i = 32'h22222222;
        readAddr1_i = 5'd7; readAddr2_i = 5'd5; #1;
`ifdef REGFILE_BYPASS_EN
        chk("r7_same_cycle", readData1_o, 32'h22222222);
`else
        chk("r7_same_cycle", readData1_o, 32'h11111111);
`endif
        chk("r5_unaffected", readData2_o, 32'hDEADBEEF);
        tick();
        writeEnable_i = 1'b0; #1;
        chk("r7_next_cycle", readData1_o, 32'h22222222);

        // read enable gating, then mid-run reset with a write in flight
        wr(5'd9, 32'h12345678);
        readEnable1_i = 1'b0; readAddr1_i = 5'd9; readAddr2_i = 5'd9; #1;
        chk("r9_en0", readData1_o, 32'h0);
        chk("r9_en1", readData2_o, 32'h12345678);
        readEnable1_i = 1'b1;
        rst = 1'b0;
        writeEnable_i = 1'b1; writeAddr_i = 5'd9; writeData_i = 32'hCAFEF00D;
        #1;
        chk("rst_comb_mask", readData2_o, 32'h0);
        tick();
        writeEnable_i = 1'b0;
        chk("rerst_ready", 32'(ready_o), 32'd0);
        chk("rerst_dropped", 32'(writeDropped_o), 32'd0);
        chk("rerst_rd1", readData1_o, 32'h0);
        chk("rerst_rd2", readData2_o, 32'h0);

        rst = 1'b1;
        do_clear(1);
        check_all_zero();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
